// File: rtl/network_bf_out_param.sv
// -----------------------------------------------------------------------------
// network_bf_out_param
//   Output-routing crossbar behind a bank of NUM_BF radix-2 butterflies.
//   Each of the NUM_OUT = 2*NUM_BF output lanes selects one butterfly
//   upper/lower result. Per-lane select words travel down a SEL_DELAY-deep
//   delay line so they meet the butterfly results they were issued for.
//   A global enable freezes every register so the block follows butterfly
//   stalls.
//
//   Optional build macro: BF_OUT_CONFLICT_CHK_EN
//     defined   -> sticky 'conflict' flag for duplicate or out-of-range
//                  lane selects on valid words, cleared by conflict_clr
//     undefined -> conflict tied low, conflict_clr ignored, no comparators
// -----------------------------------------------------------------------------
module network_bf_out_param #(
    parameter  int DATA_WIDTH = 12,
    parameter  int NUM_BF     = 2,
    parameter  int SEL_DELAY  = 13,
    localparam int NUM_OUT    = 2 * NUM_BF,
    localparam int SEL_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          sel_valid,
    input  logic [NUM_OUT*SEL_W-1:0]      sel,
    input  logic [NUM_BF*DATA_WIDTH-1:0]  bf_upper,
    input  logic [NUM_BF*DATA_WIDTH-1:0]  bf_lower,
    input  logic                          conflict_clr,
    output logic [NUM_OUT*DATA_WIDTH-1:0] dout,
    output logic                          dout_valid,
    output logic                          conflict
);

    // One delay-line entry: a routing word and whether it is a real request.
    typedef struct packed {
        logic                     valid;
        logic [NUM_OUT*SEL_W-1:0] sel;
    } stage_t;

    stage_t                        stage_q [SEL_DELAY];
    stage_t                        stage_d [SEL_DELAY];
    stage_t                        last_stage;
    logic [SEL_W-1:0]              lane_sel [NUM_OUT];
    logic [NUM_OUT*DATA_WIDTH-1:0] route_d;
    logic [NUM_OUT*DATA_WIDTH-1:0] dout_q;
    logic                          dout_valid_q;

    // Next state of the delay line: new word enters stage 0, the rest shift by one.
    always_comb begin
        stage_d[0] = '{valid: sel_valid, sel: sel};
        for (int i = 1; i < SEL_DELAY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Delay line registers; advance only on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every stage is reset (not just the valid bits) so in-flight
            // selects are discarded and stale routing never reaches dout.
            for (int i = 0; i < SEL_DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q <= stage_d;
        end
    end

    assign last_stage = stage_q[SEL_DELAY-1];

    // Unpack the aligned routing word into per-lane selects.
    always_comb begin
        for (int i = 0; i < NUM_OUT; i++) begin
            lane_sel[i] = last_stage.sel[i*SEL_W +: SEL_W];
        end
    end

    // Lane muxes: s = 2k picks butterfly k lower, s = 2k+1 picks upper,
    // anything >= NUM_OUT matches no source and stays zero.
    always_comb begin
        // NOTE: default-assign the whole vector first so no lane can infer a latch.
        route_d = '0;
        for (int lane = 0; lane < NUM_OUT; lane++) begin
            for (int k = 0; k < NUM_BF; k++) begin
                if (int'(lane_sel[lane]) == 2 * k) begin
                    route_d[lane*DATA_WIDTH +: DATA_WIDTH] = bf_lower[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (int'(lane_sel[lane]) == 2 * k + 1) begin
                    route_d[lane*DATA_WIDTH +: DATA_WIDTH] = bf_upper[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Registered outputs; hold during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (en) begin
            dout_q       <= route_d;
            dout_valid_q <= last_stage.valid;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

`ifdef BF_OUT_CONFLICT_CHK_EN
    logic conflict_hit;
    logic conflict_q;

    // Illegal routing: any lane out of range, or two lanes sharing a source.
    always_comb begin
        conflict_hit = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (int'(lane_sel[i]) >= NUM_OUT) begin
                conflict_hit = 1'b1;
            end
            for (int j = i + 1; j < NUM_OUT; j++) begin
                if (lane_sel[i] == lane_sel[j]) begin
                    conflict_hit = 1'b1;
                end
            end
        end
    end

    // Sticky flag, raised alongside the offending dout; a new hit beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else if (en) begin
            if (last_stage.valid && conflict_hit) begin
                conflict_q <= 1'b1;
            end else if (conflict_clr) begin
                conflict_q <= 1'b0;
            end
        end
    end

    assign conflict = conflict_q;
`else
    logic unused_conflict_clr;

    assign unused_conflict_clr = conflict_clr;
    assign conflict            = 1'b0;
`endif

endmodule

// File: tb/tb_network_bf_out_param.sv
// -----------------------------------------------------------------------------
// tb_network_bf_out_param
//   Scoreboard bench for network_bf_out_param (NUM_BF=2, SEL_DELAY=13) plus a
//   small NUM_BF=3 instance for out-of-range selects. The driver pushes the
//   expected output for every enabled edge; a monitor pops and compares.
//   Conflict expectations follow BF_OUT_CONFLICT_CHK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_network_bf_out_param;

    localparam int DW  = 12;
    localparam int NB  = 2;
    localparam int NO  = 4;
    localparam int SW  = 2;
    localparam int D   = 13;
    localparam int NB3 = 3;
    localparam int NO3 = 6;
    localparam int SW3 = 3;
    localparam int D3  = 2;

`ifdef BF_OUT_CONFLICT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              en;
    logic              sel_valid;
    logic [NO*SW-1:0]  sel;
    logic [NB*DW-1:0]  bf_upper;
    logic [NB*DW-1:0]  bf_lower;
    logic              conflict_clr;
    logic [NO*DW-1:0]  dout;
    logic              dout_valid;
    logic              conflict;

    logic              sel3_valid;
    logic [NO3*SW3-1:0] sel3;
    logic [NB3*DW-1:0] bf3_upper;
    logic [NB3*DW-1:0] bf3_lower;
    logic [NO3*DW-1:0] dout3;
    logic              dout3_valid;
    logic              conflict3;

    network_bf_out_param #(.DATA_WIDTH(DW), .NUM_BF(NB), .SEL_DELAY(D)) u_dut (
        .clk(clk), .rst(rst), .en(en), .sel_valid(sel_valid), .sel(sel),
        .bf_upper(bf_upper), .bf_lower(bf_lower), .conflict_clr(conflict_clr),
        .dout(dout), .dout_valid(dout_valid), .conflict(conflict)
    );

    network_bf_out_param #(.DATA_WIDTH(DW), .NUM_BF(NB3), .SEL_DELAY(D3)) u_dut3 (
        .clk(clk), .rst(rst), .en(1'b1), .sel_valid(sel3_valid), .sel(sel3),
        .bf_upper(bf3_upper), .bf_lower(bf3_lower), .conflict_clr(1'b0),
        .dout(dout3), .dout_valid(dout3_valid), .conflict(conflict3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic             v;
        logic [NO*SW-1:0] s;
    } word_t;

    typedef struct {
        logic             v;
        logic [NO*DW-1:0] d;
        logic             c;
    } exp_t;

    word_t hist[$];   // words in flight, oldest first, always D long
    exp_t  exp_q[$];  // expected output per enabled edge
    exp_t  last_exp;
    logic  conf_m;
    bit    mon_on = 1'b0;

    function automatic logic [NO*DW-1:0] route(input logic [NO*SW-1:0] s,
                                               input logic [NB*DW-1:0] up,
                                               input logic [NB*DW-1:0] lo);
        logic [NO*DW-1:0] r;
        r = '0;
        for (int lane = 0; lane < NO; lane++) begin
            int v;
            int k;
            v = int'(s[lane*SW +: SW]);
            k = v / 2;
            if (v < NO) r[lane*DW +: DW] = (v % 2 == 1) ? up[k*DW +: DW] : lo[k*DW +: DW];
        end
        return r;
    endfunction

    function automatic bit bad_route(input logic [NO*SW-1:0] s);
        for (int i = 0; i < NO; i++) begin
            if (int'(s[i*SW +: SW]) >= NO) return 1'b1;
            for (int j = i + 1; j < NO; j++) begin
                if (s[i*SW +: SW] == s[j*SW +: SW]) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < D; i++) hist.push_back('{v: 1'b0, s: '0});
        exp_q.delete();
        conf_m   = 1'b0;
        last_exp = '{v: 1'b0, d: '0, c: 1'b0};
    endtask

    function automatic logic [NB*DW-1:0] rnd_bf();
        logic [NB*DW-1:0] r;
        for (int k = 0; k < NB; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    function automatic logic [NO*SW-1:0] rnd_perm();
        int a[NO];
        logic [NO*SW-1:0] r;
        for (int i = 0; i < NO; i++) a[i] = i;
        for (int i = NO - 1; i > 0; i--) begin
            int j;
            int t;
            j    = int'($urandom_range(i, 0));
            t    = a[i];
            a[i] = a[j];
            a[j] = t;
        end
        for (int i = 0; i < NO; i++) r[i*SW +: SW] = SW'(a[i]);
        return r;
    endfunction

    // Drive one clock's worth of inputs and record what the next edge must produce.
    task automatic step(input logic e, input logic sv, input logic [NO*SW-1:0] s,
                        input logic [NB*DW-1:0] up, input logic [NB*DW-1:0] lo,
                        input logic clr);
        word_t f;
        exp_t  x;
        @(negedge clk);
        en           = e;
        sel_valid    = sv;
        sel          = s;
        bf_upper     = up;
        bf_lower     = lo;
        conflict_clr = clr;
        if (e) begin
            f = hist.pop_front();
            hist.push_back('{v: sv, s: s});
            x.v = f.v;
            x.d = route(f.s, up, lo);
            if (CHK) begin
                if (f.v && bad_route(f.s)) conf_m = 1'b1;
                else if (clr)              conf_m = 1'b0;
            end
            x.c = conf_m;
            exp_q.push_back(x);
        end
    endtask

    task automatic rnd_step(input logic e, input logic sv);
        step(e, sv, rnd_perm(), rnd_bf(), rnd_bf(), 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin : monitor
        logic en_s;
        logic rst_s;
        exp_t x;
        en_s  = en;
        rst_s = rst;
        #1;
        if (mon_on && !rst_s && !rst) begin
            if (en_s) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: output edge with no expected entry (t=%0t)", $time);
                end else begin
                    x = exp_q.pop_front();
                    check("dout_valid", dout_valid, x.v);
                    check("dout", dout, x.d);
                    check("conflict", conflict, x.c);
                    last_exp = x;
                end
            end else begin
                check("stall_dout_valid", dout_valid, last_exp.v);
                check("stall_dout", dout, last_exp.d);
                check("stall_conflict", conflict, last_exp.c);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [NO*SW-1:0]  dup;
        logic [NO3*SW3-1:0] s3;
        int                word;

        rst = 1'b1; en = 1'b0; sel_valid = 1'b0; sel = '0;
        bf_upper = '0; bf_lower = '0; conflict_clr = 1'b0;
        sel3_valid = 1'b0; sel3 = '0;
        bf3_upper  = {12'hC03, 12'hB02, 12'hA01};
        bf3_lower  = {12'h703, 12'h602, 12'h501};
        reset_model();
        repeat (2) @(negedge clk);
        check("reset_dout", dout, '0);
        check("reset_dout_valid", dout_valid, 1'b0);
        check("reset_conflict", conflict, 1'b0);
        check("reset_dout3_valid", dout3_valid, 1'b0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // T1: identity routing, exact latency
        step(1'b1, 1'b1, 8'hE4, rnd_bf(), rnd_bf(), 1'b0);
        for (int i = 1; i < D; i++) rnd_step(1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, {12'h333, 12'h111}, {12'h444, 12'h222}, 1'b0);
        rnd_step(1'b1, 1'b0);
        check("t1_dout", dout, {12'h333, 12'h444, 12'h111, 12'h222});
        check("t1_valid", dout_valid, 1'b1);
        rnd_step(1'b1, 1'b0);
        check("t1_valid_one_cycle", dout_valid, 1'b0);

        // T2: 20 back-to-back permutations
        for (int i = 0; i < 20; i++) rnd_step(1'b1, 1'b1);
        for (int i = 0; i < D + 2; i++) rnd_step(1'b1, 1'b0);

        // T3: same stream with a 5-cycle stall after 6 words
        word = 0;
        for (int i = 0; i < 25; i++) begin
            if (i >= 6 && i < 11) begin
                rnd_step(1'b0, 1'b1);
            end else begin
                rnd_step(1'b1, 1'b1);
                word++;
            end
        end
        for (int i = 0; i < D + 2; i++) rnd_step(1'b1, 1'b0);
        check("t3_words_issued", word, 20);

        // T4: asynchronous reset with 8 words in flight
        for (int i = 0; i < 8; i++) rnd_step(1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("t4_async_dout", dout, '0);
        check("t4_async_valid", dout_valid, 1'b0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        rnd_step(1'b1, 1'b1);
        for (int i = 0; i < D + 2; i++) rnd_step(1'b1, 1'b0);

        // T5: duplicate lanes, sticky flag, clear, clear vs. new hit
        dup = {2'd3, 2'd2, 2'd1, 2'd1};
        step(1'b1, 1'b1, dup, rnd_bf(), rnd_bf(), 1'b0);
        for (int i = 0; i < 4; i++) rnd_step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, rnd_perm(), rnd_bf(), rnd_bf(), i == 12);
        step(1'b1, 1'b1, dup, rnd_bf(), rnd_bf(), 1'b0);
        for (int i = 0; i < D - 1; i++) rnd_step(1'b1, 1'b0);
        step(1'b1, 1'b0, rnd_perm(), rnd_bf(), rnd_bf(), 1'b1);
        for (int i = 0; i < 3; i++) rnd_step(1'b1, 1'b0);

        // Random mix: stalls, invalid words, arbitrary selects, clears
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, NO*SW'($urandom),
                 rnd_bf(), rnd_bf(), ($urandom % 8) == 0);
        end
        for (int i = 0; i < D + 2; i++) rnd_step(1'b1, 1'b0);

        // T6: NUM_BF=3 instance, lanes 0/1 out of range
        s3 = '0;
        s3[0*SW3 +: SW3] = 3'd7;
        s3[1*SW3 +: SW3] = 3'd6;
        s3[2*SW3 +: SW3] = 3'd0;
        s3[3*SW3 +: SW3] = 3'd1;
        s3[4*SW3 +: SW3] = 3'd4;
        s3[5*SW3 +: SW3] = 3'd5;
        rnd_step(1'b1, 1'b0);
        sel3       = s3;
        sel3_valid = 1'b1;
        rnd_step(1'b1, 1'b0);
        sel3_valid = 1'b0;
        sel3       = '0;
        rnd_step(1'b1, 1'b0);
        rnd_step(1'b1, 1'b0);
        check("t6_dout3", dout3, {12'hC03, 12'h703, 12'hA01, 12'h501, 12'h000, 12'h000});
        check("t6_valid3", dout3_valid, 1'b1);
        check("t6_conflict3", conflict3, CHK);

        // Drain and confirm every expected word was seen
        step(1'b0, 1'b0, '0, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        check("sb_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
